// File: rtl/delay_meas_pkg.sv
// Shared types and constants for the path-delay measurement back end.
package delay_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LAUNCH,
    MEASURE,
    WAIT_FIN,
    REPORT
  } state_e;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_NUM_TRIALS = 16;

  // Saturation value of a counter of the given width.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/delay_stat_update.sv
// Next-value logic for the running sum/min/max given a newly captured sample.
module delay_stat_update #(
  parameter int CNT_W = 8,
  parameter int SUM_W = 13
) (
  input  logic [SUM_W-1:0] sum_i,
  input  logic [CNT_W-1:0] min_i,
  input  logic [CNT_W-1:0] max_i,
  input  logic [CNT_W-1:0] sample_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o
);

  assign sum_o = sum_i + SUM_W'(sample_i);
  assign min_o = (sample_i < min_i) ? sample_i : min_i;
  assign max_o = (sample_i > max_i) ? sample_i : max_i;

endmodule

// File: rtl/delay_sample_accumulator.sv
// Counts pathInput-high cycles up to each ld_reg strobe and accumulates
// sum/min/max over a run of NUM_TRIALS trials, reported under valid/ready.
//
//   state       | meaning
//   IDLE        | waiting for arm
//   WAIT_LAUNCH | waiting for the controller to raise path_input
//   MEASURE     | counting cycles until ld_reg (or saturation)
//   WAIT_FIN    | sample taken, waiting for fin to close the trial
//   REPORT      | results held, waiting for result_ready
module delay_sample_accumulator
  import delay_meas_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NUM_TRIALS = DEF_NUM_TRIALS,
  parameter int SUM_W      = CNT_W + $clog2(NUM_TRIALS + 1),
  localparam int TD_W      = $clog2(NUM_TRIALS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             path_input,
  input  logic             ld_reg,
  input  logic             fin,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [SUM_W-1:0] sample_sum,
  output logic [CNT_W-1:0] sample_min,
  output logic [CNT_W-1:0] sample_max,
  output logic [TD_W-1:0]  trials_done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_max(CNT_W));
  localparam logic [TD_W-1:0]  TD_END  = TD_W'(NUM_TRIALS);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [TD_W-1:0]  td_q, td_d;
  logic             timeout_q;
  logic             busy_q;
  logic             valid_q;

  delay_stat_update #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_stat (
    .sum_i    (sum_q),
    .min_i    (min_q),
    .max_i    (max_q),
    .sample_i (cnt_q),
    .sum_o    (sum_d),
    .min_o    (min_d),
    .max_o    (max_d)
  );

  assign td_d = td_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      min_q     <= '1;
      max_q     <= '0;
      td_q      <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            sum_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            td_q      <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= WAIT_LAUNCH;
          end
        end
        WAIT_LAUNCH: begin
          if (path_input) begin
            cnt_q   <= CNT_W'(1);
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          // ld_reg outranks path_input: the capture edge never increments.
          if (ld_reg) begin
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            state_q <= WAIT_FIN;
          end else if (path_input && (cnt_q == CNT_SAT)) begin
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= REPORT;
          end else if (path_input) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_FIN: begin
          if (fin) begin
            td_q <= td_d;
            if (td_d == TD_END) begin
              valid_q <= 1'b1;
              state_q <= REPORT;
            end else begin
              state_q <= WAIT_LAUNCH;
            end
          end
        end
        REPORT: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign sample_sum   = sum_q;
  assign sample_min   = min_q;
  assign sample_max   = max_q;
  assign trials_done  = td_q;
  assign timeout      = timeout_q;

endmodule
